// File: rtl/ast_width_converter.sv
// Avalon-ST packet width converter: upsizes, downsizes or passes through by parameter.
// Latency: 1 cycle from the completing sink transfer to the source word (slice 0 when downsizing).
// Backpressure: sink ready drops while the source is stalled or while downsize slices are still pending.
module ast_width_converter #(
  parameter int DATA_IN_W   = 64,
  parameter int DATA_OUT_W  = 256,
  parameter int CHANNEL_W   = 10,
  parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W / 8) > 1) ? $clog2(DATA_IN_W / 8) : 1,
  parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i,
  output logic                   err_o
);

  // Equal widths take the upsize path with a ratio of one: every beat completes a word.
  localparam bit UPSIZE   = (DATA_OUT_W >= DATA_IN_W);
  localparam int RATIO    = UPSIZE ? (DATA_OUT_W / DATA_IN_W) : (DATA_IN_W / DATA_OUT_W);
  localparam int K_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IN_BYTES = DATA_IN_W / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  pkt_state_e           state_q;
  pkt_state_e           state_d;
  logic [CHANNEL_W-1:0] ch_q;
  logic [CHANNEL_W-1:0] beat_ch;
  logic                 sink_xfer;
  logic                 accept;
  logic                 err_d;
  logic                 err_q;

  assign sink_xfer = ast_valid_i & ast_ready_o;
  assign err_o     = err_q;

  // Packet state, latched channel and the registered error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept && ast_startofpacket_i) begin
        ch_q <= ast_channel_i;
      end
    end
  end

  // Classify each sink transfer: accept into the datapath, drop, or flag a protocol error.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    beat_ch = ast_startofpacket_i ? ast_channel_i : ch_q;
    if (sink_xfer) begin
      case (state_q)
        IDLE: begin
          if (ast_startofpacket_i) begin
            accept  = 1'b1;
            state_d = ast_endofpacket_i ? IDLE : IN_PKT;
          end else begin
            err_d = 1'b1;
          end
        end
        IN_PKT: begin
          accept  = 1'b1;
          state_d = ast_endofpacket_i ? IDLE : IN_PKT;
          if (ast_startofpacket_i) begin
            err_d = 1'b1;
          end else if (ast_channel_i != ch_q) begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  if (UPSIZE) begin : g_up
    logic [DATA_OUT_W-1:0]  acc_q;
    logic [DATA_OUT_W-1:0]  acc_nxt;
    logic [K_W-1:0]         k_q;
    logic [K_W-1:0]         k_cur;
    logic                   wsop_q;
    logic                   complete;
    logic                   word_sop;
    logic [EMPTY_OUT_W-1:0] word_emp;
    logic                   out_vld_q;
    logic [DATA_OUT_W-1:0]  out_dat_q;
    logic                   out_sop_q;
    logic                   out_eop_q;
    logic [EMPTY_OUT_W-1:0] out_emp_q;
    logic [CHANNEL_W-1:0]   out_ch_q;

    // Merge the current beat into its lane; a SOP beat restarts the word from an empty accumulator.
    always_comb begin
      k_cur    = ast_startofpacket_i ? '0 : k_q;
      acc_nxt  = ast_startofpacket_i ? '0 : acc_q;
      acc_nxt[(RATIO - 1 - int'(k_cur)) * DATA_IN_W +: DATA_IN_W] = ast_data_i;
      complete = accept & (ast_endofpacket_i | (k_cur == K_W'(RATIO - 1)));
      word_sop = ast_startofpacket_i | wsop_q;
      word_emp = ast_endofpacket_i ?
                 EMPTY_OUT_W'((RATIO - 1 - int'(k_cur)) * IN_BYTES + int'(ast_empty_i)) : '0;
    end

    // Accumulator and lane counter; cleared whenever a word is handed to the output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        acc_q  <= '0;
        k_q    <= '0;
        wsop_q <= 1'b0;
      end else if (accept) begin
        if (complete) begin
          acc_q  <= '0;
          k_q    <= '0;
          wsop_q <= 1'b0;
        end else begin
          acc_q  <= acc_nxt;
          k_q    <= k_cur + 1'b1;
          wsop_q <= word_sop;
        end
      end
    end

    // Single output register; sink ready guarantees it is free whenever a word completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_vld_q <= 1'b0;
        out_dat_q <= '0;
        out_sop_q <= 1'b0;
        out_eop_q <= 1'b0;
        out_emp_q <= '0;
        out_ch_q  <= '0;
      end else if (complete) begin
        out_vld_q <= 1'b1;
        out_dat_q <= acc_nxt;
        out_sop_q <= word_sop;
        out_eop_q <= ast_endofpacket_i;
        out_emp_q <= word_emp;
        out_ch_q  <= beat_ch;
      end else if (ast_ready_i) begin
        out_vld_q <= 1'b0;
      end
    end

    assign ast_ready_o         = rst_ni & ~(out_vld_q & ~ast_ready_i);
    assign ast_valid_o         = out_vld_q;
    assign ast_data_o          = out_dat_q;
    assign ast_startofpacket_o = out_sop_q;
    assign ast_endofpacket_o   = out_eop_q;
    assign ast_empty_o         = out_emp_q;
    assign ast_channel_o       = out_ch_q;
  end else begin : g_down
    logic [DATA_IN_W-1:0]  word_q;
    logic [K_W-1:0]        idx_q;
    logic [K_W-1:0]        last_q;
    logic [K_W-1:0]        last_d;
    logic                  pend_q;
    logic                  sop_q;
    logic                  eop_q;
    logic [EMPTY_IN_W-1:0] emp_q;
    logic [CHANNEL_W-1:0]  wch_q;
    logic                  last_slice;

    // Index of the slice holding the last valid byte; trailing all-empty slices are skipped.
    always_comb begin
      last_d = ast_endofpacket_i ?
               K_W'((IN_BYTES - 1 - int'(ast_empty_i)) / (DATA_OUT_W / 8)) : K_W'(RATIO - 1);
    end

    // Word holding register and slice pointer; a new word loads as the final slice leaves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        word_q <= '0;
        idx_q  <= '0;
        last_q <= '0;
        pend_q <= 1'b0;
        sop_q  <= 1'b0;
        eop_q  <= 1'b0;
        emp_q  <= '0;
        wch_q  <= '0;
      end else begin
        if (pend_q && ast_ready_i) begin
          if (last_slice) begin
            pend_q <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        if (accept) begin
          word_q <= ast_data_i;
          idx_q  <= '0;
          last_q <= last_d;
          pend_q <= 1'b1;
          sop_q  <= ast_startofpacket_i;
          eop_q  <= ast_endofpacket_i;
          emp_q  <= ast_endofpacket_i ? ast_empty_i : '0;
          wch_q  <= beat_ch;
        end
      end
    end

    assign last_slice          = (idx_q == last_q);
    assign ast_ready_o         = rst_ni & (~pend_q | (last_slice & ast_ready_i));
    assign ast_valid_o         = pend_q;
    assign ast_data_o          = word_q[(RATIO - 1 - int'(idx_q)) * DATA_OUT_W +: DATA_OUT_W];
    assign ast_startofpacket_o = pend_q & sop_q & (idx_q == '0);
    assign ast_endofpacket_o   = pend_q & eop_q & last_slice;
    assign ast_empty_o         = ast_endofpacket_o ?
                                 EMPTY_OUT_W'(int'(emp_q) % (DATA_OUT_W / 8)) : '0;
    assign ast_channel_o       = wch_q;
  end

endmodule

// File: tb/tb_ast_width_converter.sv
// Directed bench for a 64->256 upsizing and a 256->64 downsizing instance.
// Latency: n/a.
// Backpressure: source ready is driven by the bench, including a toggling pattern.
module tb_ast_width_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Free-running cycle stamp for throughput checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Upsizer (64 -> 256) signals
  logic [63:0]  u_din;
  logic         u_sop_i, u_eop_i, u_vld_i, u_rdy_o;
  logic [2:0]   u_emp_i;
  logic [9:0]   u_ch_i;
  logic [255:0] u_dout;
  logic         u_sop_o, u_eop_o, u_vld_o, u_rdy_i, u_err;
  logic [4:0]   u_emp_o;
  logic [9:0]   u_ch_o;

  // Downsizer (256 -> 64) signals
  logic [255:0] d_din;
  logic         d_sop_i, d_eop_i, d_vld_i, d_rdy_o;
  logic [4:0]   d_emp_i;
  logic [9:0]   d_ch_i;
  logic [63:0]  d_dout;
  logic         d_sop_o, d_eop_o, d_vld_o, d_rdy_i, d_err;
  logic [2:0]   d_emp_o;
  logic [9:0]   d_ch_o;

  ast_width_converter #(.DATA_IN_W(64), .DATA_OUT_W(256), .CHANNEL_W(10),
                        .EMPTY_IN_W(3), .EMPTY_OUT_W(5)) u_up (
    .clk_i(clk), .rst_ni(rst_n),
    .ast_data_i(u_din), .ast_startofpacket_i(u_sop_i), .ast_endofpacket_i(u_eop_i),
    .ast_valid_i(u_vld_i), .ast_empty_i(u_emp_i), .ast_channel_i(u_ch_i), .ast_ready_o(u_rdy_o),
    .ast_data_o(u_dout), .ast_startofpacket_o(u_sop_o), .ast_endofpacket_o(u_eop_o),
    .ast_valid_o(u_vld_o), .ast_empty_o(u_emp_o), .ast_channel_o(u_ch_o), .ast_ready_i(u_rdy_i),
    .err_o(u_err)
  );

  ast_width_converter #(.DATA_IN_W(256), .DATA_OUT_W(64), .CHANNEL_W(10),
                        .EMPTY_IN_W(5), .EMPTY_OUT_W(3)) u_dn (
    .clk_i(clk), .rst_ni(rst_n),
    .ast_data_i(d_din), .ast_startofpacket_i(d_sop_i), .ast_endofpacket_i(d_eop_i),
    .ast_valid_i(d_vld_i), .ast_empty_i(d_emp_i), .ast_channel_i(d_ch_i), .ast_ready_o(d_rdy_o),
    .ast_data_o(d_dout), .ast_startofpacket_o(d_sop_o), .ast_endofpacket_o(d_eop_o),
    .ast_valid_o(d_vld_o), .ast_empty_o(d_emp_o), .ast_channel_o(d_ch_o), .ast_ready_i(d_rdy_i),
    .err_o(d_err)
  );

  typedef struct {
    logic [255:0] d;
    logic         sop;
    logic         eop;
    logic [4:0]   emp;
    logic [9:0]   ch;
    int           cyc;
  } urec_t;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  emp;
    logic [9:0]  ch;
    int          cyc;
  } drec_t;

  urec_t u_q[$];
  drec_t d_q[$];
  int    u_err_cnt = 0;
  int    d_err_cnt = 0;
  int    u_stab_bad = 0;
  logic         u_hold_v = 1'b0;
  logic [255:0] u_hold_d = '0;
  logic         u_hold_s = 1'b0, u_hold_e = 1'b0;
  logic [4:0]   u_hold_m = '0;

  int n_chk = 0;
  int n_pass = 0;

  // Upsizer source monitor: captures transfers, error pulses and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      u_hold_v <= 1'b0;
    end else begin
      if (u_vld_o && u_rdy_i) u_q.push_back('{u_dout, u_sop_o, u_eop_o, u_emp_o, u_ch_o, cyc});
      if (u_err) u_err_cnt <= u_err_cnt + 1;
      if (u_hold_v && (!u_vld_o || u_dout != u_hold_d || u_sop_o != u_hold_s ||
                       u_eop_o != u_hold_e || u_emp_o != u_hold_m))
        u_stab_bad <= u_stab_bad + 1;
      u_hold_v <= u_vld_o && !u_rdy_i;
      u_hold_d <= u_dout;
      u_hold_s <= u_sop_o;
      u_hold_e <= u_eop_o;
      u_hold_m <= u_emp_o;
    end
  end

  // Downsizer source monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (d_vld_o && d_rdy_i) d_q.push_back('{d_dout, d_sop_o, d_eop_o, d_emp_o, d_ch_o, cyc});
      if (d_err) d_err_cnt <= d_err_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic up_beat(input logic [63:0] d, input logic s, input logic e,
                         input logic [2:0] em, input logic [9:0] c);
    int n = 0;
    u_din = d; u_sop_i = s; u_eop_i = e; u_emp_i = em; u_ch_i = c; u_vld_i = 1'b1;
    @(negedge clk);
    while (!u_rdy_o && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) check("up_sink_wait", u_rdy_o, 1'b1);
    @(posedge clk); #1;
    u_vld_i = 1'b0; u_sop_i = 1'b0; u_eop_i = 1'b0;
  endtask

  task automatic up_pkt(input logic [63:0] first, input int nb, input logic [2:0] em,
                        input logic [9:0] c);
    for (int i = 0; i < nb; i++)
      up_beat(first + 64'(i), i == 0, i == nb - 1, (i == nb - 1) ? em : 3'd0, c);
  endtask

  task automatic dn_beat(input logic [255:0] d, input logic s, input logic e,
                         input logic [4:0] em, input logic [9:0] c);
    int n = 0;
    d_din = d; d_sop_i = s; d_eop_i = e; d_emp_i = em; d_ch_i = c; d_vld_i = 1'b1;
    @(negedge clk);
    while (!d_rdy_o && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) check("dn_sink_wait", d_rdy_o, 1'b1);
    @(posedge clk); #1;
    d_vld_i = 1'b0; d_sop_i = 1'b0; d_eop_i = 1'b0;
  endtask

  task automatic wait_up(input string tag, input int base, input int n);
    int t = 0;
    while (u_q.size() < base + n && t < 300) begin t++; @(negedge clk); end
    repeat (6) @(negedge clk);
    check(tag, u_q.size() - base, n);
    @(posedge clk); #1;
  endtask

  task automatic wait_dn(input string tag, input int base, input int n);
    int t = 0;
    while (d_q.size() < base + n && t < 300) begin t++; @(negedge clk); end
    repeat (6) @(negedge clk);
    check(tag, d_q.size() - base, n);
    @(posedge clk); #1;
  endtask

  task automatic up_expect(input string tag, input int i, input logic [255:0] d, input logic s,
                           input logic e, input logic [4:0] em, input logic [9:0] c);
    check({tag, "_dat"}, u_q[i].d, d);
    check({tag, "_sop"}, u_q[i].sop, s);
    check({tag, "_eop"}, u_q[i].eop, e);
    check({tag, "_emp"}, u_q[i].emp, em);
    check({tag, "_ch"}, u_q[i].ch, c);
  endtask

  task automatic dn_expect(input string tag, input int i, input logic [63:0] d, input logic s,
                           input logic e, input logic [2:0] em, input logic [9:0] c);
    check({tag, "_dat"}, d_q[i].d, d);
    check({tag, "_sop"}, d_q[i].sop, s);
    check({tag, "_eop"}, d_q[i].eop, e);
    check({tag, "_emp"}, d_q[i].emp, em);
    check({tag, "_ch"}, d_q[i].ch, c);
  endtask

  logic [23:0] bp_pat = 24'b1011_0010_1100_1110_0101_1001;

  initial begin
    int ub, db, eb;
    u_din = '0; u_sop_i = 0; u_eop_i = 0; u_vld_i = 0; u_emp_i = '0; u_ch_i = '0; u_rdy_i = 1;
    d_din = '0; d_sop_i = 0; d_eop_i = 0; d_vld_i = 0; d_emp_i = '0; d_ch_i = '0; d_rdy_i = 1;

    // Reset state
    #23;
    check("rst_u_vld", u_vld_o, 1'b0);
    check("rst_u_rdy", u_rdy_o, 1'b0);
    check("rst_u_dat", u_dout, 256'd0);
    check("rst_u_err", u_err, 1'b0);
    check("rst_d_vld", d_vld_o, 1'b0);
    check("rst_d_rdy", d_rdy_o, 1'b0);
    check("rst_d_dat", d_dout, 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    #1;
    check("post_rst_u_rdy", u_rdy_o, 1'b1);
    check("post_rst_d_rdy", d_rdy_o, 1'b1);
    @(posedge clk); #1;

    // Upsize: 8 beats -> two full words at one beat per cycle
    ub = u_q.size(); eb = u_err_cnt;
    up_pkt(64'h01, 8, 3'd0, 10'h155);
    wait_up("up8_cnt", ub, 2);
    up_expect("up8_w0", ub, {64'h1, 64'h2, 64'h3, 64'h4}, 1'b1, 1'b0, 5'd0, 10'h155);
    up_expect("up8_w1", ub + 1, {64'h5, 64'h6, 64'h7, 64'h8}, 1'b0, 1'b1, 5'd0, 10'h155);
    check("up8_gap", u_q[ub + 1].cyc - u_q[ub].cyc, 4);
    check("up8_err", u_err_cnt - eb, 0);

    // Upsize: 5 beats, last empty 3 -> tail word in MSB lane, empty 3*8+3
    ub = u_q.size();
    up_pkt(64'h11, 5, 3'd3, 10'h0A3);
    wait_up("up5_cnt", ub, 2);
    up_expect("up5_w0", ub, {64'h11, 64'h12, 64'h13, 64'h14}, 1'b1, 1'b0, 5'd0, 10'h0A3);
    up_expect("up5_w1", ub + 1, {64'h15, 64'h0, 64'h0, 64'h0}, 1'b0, 1'b1, 5'd27, 10'h0A3);

    // Downsize: one SOP+EOP word with empty 20 -> 12 valid bytes -> two slices, last empty 4
    db = d_q.size();
    dn_beat(256'h0102030405060708_090a0b0c0d0e0f10_1112131415161718_191a1b1c1d1e1f20,
            1'b1, 1'b1, 5'd20, 10'h2AA);
    wait_dn("dn1_cnt", db, 2);
    dn_expect("dn1_s0", db, 64'h0102030405060708, 1'b1, 1'b0, 3'd0, 10'h2AA);
    dn_expect("dn1_s1", db + 1, 64'h090a0b0c0d0e0f10, 1'b0, 1'b1, 3'd4, 10'h2AA);

    // Downsize: two-word packet, slices back to back with no bubble between words
    db = d_q.size(); eb = d_err_cnt;
    dn_beat({64'hA0, 64'hA1, 64'hA2, 64'hA3}, 1'b1, 1'b0, 5'd0, 10'h013);
    dn_beat({64'hB0, 64'hB1, 64'hB2, 64'hB3}, 1'b0, 1'b1, 5'd0, 10'h013);
    wait_dn("dn2_cnt", db, 8);
    dn_expect("dn2_s0", db, 64'hA0, 1'b1, 1'b0, 3'd0, 10'h013);
    dn_expect("dn2_s3", db + 3, 64'hA3, 1'b0, 1'b0, 3'd0, 10'h013);
    dn_expect("dn2_s4", db + 4, 64'hB0, 1'b0, 1'b0, 3'd0, 10'h013);
    dn_expect("dn2_s7", db + 7, 64'hB3, 1'b0, 1'b1, 3'd0, 10'h013);
    check("dn2_span", d_q[db + 7].cyc - d_q[db].cyc, 7);
    check("dn2_err", d_err_cnt - eb, 0);

    // Upsize under toggling source ready: 10 beats, nothing lost or duplicated
    ub = u_q.size();
    fork
      up_pkt(64'h21, 10, 3'd0, 10'h03C);
      begin
        for (int i = 0; i < 48; i++) begin
          @(posedge clk); #1;
          u_rdy_i = bp_pat[i % 24];
        end
        u_rdy_i = 1'b1;
      end
    join
    wait_up("bp_cnt", ub, 3);
    up_expect("bp_w0", ub, {64'h21, 64'h22, 64'h23, 64'h24}, 1'b1, 1'b0, 5'd0, 10'h03C);
    up_expect("bp_w1", ub + 1, {64'h25, 64'h26, 64'h27, 64'h28}, 1'b0, 1'b0, 5'd0, 10'h03C);
    up_expect("bp_w2", ub + 2, {64'h29, 64'h2A, 64'h0, 64'h0}, 1'b0, 1'b1, 5'd16, 10'h03C);
    check("bp_hold", u_stab_bad, 0);

    // Beat without SOP while idle: dropped, single error pulse
    ub = u_q.size(); eb = u_err_cnt;
    up_beat(64'hDEAD, 1'b0, 1'b0, 3'd0, 10'h055);
    wait_up("drop_cnt", ub, 0);
    check("drop_err", u_err_cnt - eb, 1);

    // SOP after two beats: partial word discarded, new packet intact
    ub = u_q.size(); eb = u_err_cnt;
    up_beat(64'h31, 1'b1, 1'b0, 3'd0, 10'h011);
    up_beat(64'h32, 1'b0, 1'b0, 3'd0, 10'h011);
    up_pkt(64'h41, 4, 3'd0, 10'h077);
    wait_up("resop_cnt", ub, 1);
    up_expect("resop_w0", ub, {64'h41, 64'h42, 64'h43, 64'h44}, 1'b1, 1'b1, 5'd0, 10'h077);
    check("resop_err", u_err_cnt - eb, 1);

    // Channel change mid-packet: flagged, latched channel kept
    ub = u_q.size(); eb = u_err_cnt;
    up_beat(64'h51, 1'b1, 1'b0, 3'd0, 10'h100);
    up_beat(64'h52, 1'b0, 1'b0, 3'd0, 10'h101);
    up_beat(64'h53, 1'b0, 1'b0, 3'd0, 10'h100);
    up_beat(64'h54, 1'b0, 1'b1, 3'd0, 10'h100);
    wait_up("chg_cnt", ub, 1);
    up_expect("chg_w0", ub, {64'h51, 64'h52, 64'h53, 64'h54}, 1'b1, 1'b1, 5'd0, 10'h100);
    check("chg_err", u_err_cnt - eb, 1);

    // Reset mid-packet with both sources stalled holding data
    u_rdy_i = 1'b0; d_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) up_beat(64'h61 + 64'(i), i == 0, 1'b0, 3'd0, 10'h022);
    dn_beat({64'hE0, 64'hE1, 64'hE2, 64'hE3}, 1'b1, 1'b0, 5'd0, 10'h022);
    check("pre_rst_u_vld", u_vld_o, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_u_vld", u_vld_o, 1'b0);
    check("mid_rst_u_dat", u_dout, 256'd0);
    check("mid_rst_u_sop", u_sop_o, 1'b0);
    check("mid_rst_u_rdy", u_rdy_o, 1'b0);
    check("mid_rst_d_vld", d_vld_o, 1'b0);
    check("mid_rst_d_dat", d_dout, 64'd0);
    @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    u_rdy_i = 1'b1; d_rdy_i = 1'b1;
    ub = u_q.size(); db = d_q.size();
    up_pkt(64'h71, 4, 3'd0, 10'h0F0);
    wait_up("rec_up_cnt", ub, 1);
    up_expect("rec_up_w0", ub, {64'h71, 64'h72, 64'h73, 64'h74}, 1'b1, 1'b1, 5'd0, 10'h0F0);
    dn_beat({64'hC0, 64'hC1, 64'hC2, 64'hC3}, 1'b1, 1'b1, 5'd0, 10'h0F0);
    wait_dn("rec_dn_cnt", db, 4);
    dn_expect("rec_dn_s0", db, 64'hC0, 1'b1, 1'b0, 3'd0, 10'h0F0);
    dn_expect("rec_dn_s3", db + 3, 64'hC3, 1'b0, 1'b1, 3'd0, 10'h0F0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
